// File: rtl/cl_pkg.sv
// Shared types and constants for the multi-cycle control unit: state encoding,
// opcode values and default field widths.
package cl_pkg;

  localparam int CL_INSTR_W = 16;
  localparam int CL_OPC_W   = 4;
  localparam int CL_REG_AW  = 3;
  localparam int CL_PC_W    = 8;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    WB,
    HALT
  } state_e;

  localparam int OP_ADD   = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_AND   = 2;
  localparam int OP_OR    = 3;
  localparam int OP_XOR   = 4;
  localparam int OP_ADDI  = 5;
  localparam int OP_LOAD  = 6;
  localparam int OP_STORE = 7;
  localparam int OP_BEQ   = 8;
  localparam int OP_JMP   = 9;
  localparam int OP_HALT  = 14;
  localparam int OP_NOP   = 15;

endpackage

// File: rtl/cl_decoder.sv
// Combinational opcode decoder: derives operand/write-back selects and the
// per-instruction class flags that the control FSM acts on.
module cl_decoder
  import cl_pkg::*;
#(
  parameter int OPC_W = CL_OPC_W
) (
  input  logic [OPC_W-1:0] opcode_i,
  output logic             src2Sel_o,
  output logic             aluOutSel_o,
  output logic             writesReg_o,
  output logic             writesMem_o,
  output logic             isBranch_o,
  output logic             isJump_o,
  output logic             isHalt_o,
  output logic             isIllegal_o
);

  // LOAD and STORE form their address as rs1 + immediate, so they use operand B = imm too.
  always_comb begin
    src2Sel_o   = 1'b0;
    aluOutSel_o = 1'b0;
    writesReg_o = 1'b0;
    writesMem_o = 1'b0;
    isBranch_o  = 1'b0;
    isJump_o    = 1'b0;
    isHalt_o    = 1'b0;
    isIllegal_o = 1'b0;
    case (opcode_i)
      OPC_W'(OP_ADD), OPC_W'(OP_SUB), OPC_W'(OP_AND),
      OPC_W'(OP_OR),  OPC_W'(OP_XOR): writesReg_o = 1'b1;
      OPC_W'(OP_ADDI): begin
        writesReg_o = 1'b1;
        src2Sel_o   = 1'b1;
      end
      OPC_W'(OP_LOAD): begin
        writesReg_o = 1'b1;
        src2Sel_o   = 1'b1;
        aluOutSel_o = 1'b1;
      end
      OPC_W'(OP_STORE): begin
        writesMem_o = 1'b1;
        src2Sel_o   = 1'b1;
      end
      OPC_W'(OP_BEQ):  isBranch_o = 1'b1;
      OPC_W'(OP_JMP):  isJump_o   = 1'b1;
      OPC_W'(OP_HALT): isHalt_o   = 1'b1;
      OPC_W'(OP_NOP):  ;
      default:         isIllegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_logic_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control unit owning PC and IR.
// Optional macro CL_PERF_CNT_EN adds saturating instret/stall_cnt counters.
module control_logic_fsm
  import cl_pkg::*;
#(
  parameter int INSTR_W = CL_INSTR_W,
  parameter int OPC_W   = CL_OPC_W,
  parameter int REG_AW  = CL_REG_AW,
  parameter int PC_W    = CL_PC_W,
  parameter int IMM_W   = INSTR_W - OPC_W - 2 * REG_AW
) (
  input  logic               clk,
  input  logic               rstn,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               alu_zero,
  output logic [OPC_W-1:0]   OPCODE,
  output logic [REG_AW-1:0]  Wreg_Sig,
  output logic [REG_AW-1:0]  Rreg_Sig1,
  output logic [REG_AW-1:0]  Rreg_Sig2,
  output logic [IMM_W-1:0]   Immediate_Addr,
  output logic [PC_W-1:0]    Jump_addr,
  output logic               Source2_select,
  output logic               ALU_out_Select,
  output logic               PC_select,
  output logic               reg_we,
  output logic               mem_we,
  output logic               halted,
  output logic               illegal
`ifdef CL_PERF_CNT_EN
  ,
  output logic [31:0]        instret,
  output logic [31:0]        stall_cnt
`endif
);

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               taken_q, taken_d;

  logic decSrc2Sel, decAluOutSel, decWritesReg, decWritesMem;
  logic decIsBranch, decIsJump, decIsHalt, decIsIllegal;
  logic [PC_W-1:0] pcPlusOne, branchTarget;
  logic            inFlight;

  cl_decoder #(.OPC_W(OPC_W)) uDecoder (
    .opcode_i    (OPCODE),
    .src2Sel_o   (decSrc2Sel),
    .aluOutSel_o (decAluOutSel),
    .writesReg_o (decWritesReg),
    .writesMem_o (decWritesMem),
    .isBranch_o  (decIsBranch),
    .isJump_o    (decIsJump),
    .isHalt_o    (decIsHalt),
    .isIllegal_o (decIsIllegal)
  );

  assign OPCODE         = ir_q[INSTR_W-1 -: OPC_W];
  assign Wreg_Sig       = ir_q[INSTR_W-OPC_W-1 -: REG_AW];
  assign Rreg_Sig1      = ir_q[INSTR_W-OPC_W-REG_AW-1 -: REG_AW];
  assign Rreg_Sig2      = ir_q[INSTR_W-OPC_W-2*REG_AW-1 -: REG_AW];
  assign Immediate_Addr = ir_q[IMM_W-1:0];
  assign Jump_addr      = ir_q[PC_W-1:0];

  // Selects are only meaningful while an instruction is in flight; IR keeps the old word during FETCH.
  assign inFlight       = (state_q == DECODE) || (state_q == EXEC) || (state_q == WB);
  assign Source2_select = inFlight & decSrc2Sel;
  assign ALU_out_Select = inFlight & decAluOutSel;

  // Gating with rstn drops the request while reset is held, so no new fetch is launched.
  assign imem_req  = (state_q == FETCH) & rstn;
  assign imem_addr = pc_q;
  assign halted    = (state_q == HALT);

  assign pcPlusOne    = pc_q + PC_W'(1);
  assign branchTarget = pcPlusOne + PC_W'($signed(ir_q[IMM_W-1:0]));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      taken_q <= taken_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    taken_d   = taken_q;
    reg_we    = 1'b0;
    mem_we    = 1'b0;
    PC_select = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      FETCH: begin
        if (imem_valid) begin
          ir_d    = imem_rdata;
          taken_d = 1'b0;
          state_d = DECODE;
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        taken_d = decIsJump | (decIsBranch & alu_zero);
        state_d = WB;
      end
      WB: begin
        reg_we    = decWritesReg;
        mem_we    = decWritesMem;
        PC_select = taken_q;
        illegal   = decIsIllegal;
        if (decIsHalt) begin
          state_d = HALT;
        end else begin
          state_d = FETCH;
          if (taken_q) begin
            pc_d = decIsJump ? Jump_addr : branchTarget;
          end else begin
            pc_d = pcPlusOne;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

`ifdef CL_PERF_CNT_EN
  logic [31:0] instret_q, instret_d;
  logic [31:0] stallCnt_q, stallCnt_d;

  always_comb begin
    instret_d  = instret_q;
    stallCnt_d = stallCnt_q;
    if ((state_q == WB) && (instret_q != '1)) begin
      instret_d = instret_q + 32'd1;
    end
    if ((state_q == FETCH) && !imem_valid && (stallCnt_q != '1)) begin
      stallCnt_d = stallCnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      instret_q  <= '0;
      stallCnt_q <= '0;
    end else begin
      instret_q  <= instret_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign instret   = instret_q;
  assign stall_cnt = stallCnt_q;
`else
  // Counters are compiled out together with their ports.
`endif

endmodule

// File: doc/control_logic_fsm.md
Name: control_logic_fsm

Overview:
- Parametrised multi-cycle control unit for the 16-bit custom processor.
- Fetches instructions from instruction memory over a req/valid handshake and latches them into an instruction register (IR).
- Sequences each instruction through FETCH/DECODE/EXEC/WB, then drives the datapath selects, register addresses, immediate, jump target and write enables.
- Owns the PC, sits between instruction memory and the register file/ALU datapath, and generalises the fixed 16-bit control logic in width.

Parameters:
- INSTR_W, 16, instruction width.
- OPC_W, 4, opcode field width, IR[INSTR_W-1 -: OPC_W].
- REG_AW, 3, register address width (register file has 2^REG_AW entries).
- PC_W, 8, PC and instruction address width; must be <= INSTR_W-OPC_W.
- IMM_W, INSTR_W-OPC_W-2*REG_AW (6 at defaults), immediate field width.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  fetch address (equals PC).
- imem_valid  in  1  instruction data valid.
- imem_rdata  in  INSTR_W  instruction word.
- alu_zero  in  1  ALU zero flag from the datapath.
- OPCODE  out  OPC_W  IR opcode field.
- Wreg_Sig  out  REG_AW  rd = IR[INSTR_W-OPC_W-1 -: REG_AW].
- Rreg_Sig1  out  REG_AW  rs1 = next REG_AW bits.
- Rreg_Sig2  out  REG_AW  rs2 = next REG_AW bits (low bits of the immediate region).
- Immediate_Addr  out  IMM_W  IR[IMM_W-1:0].
- Jump_addr  out  PC_W  IR[PC_W-1:0].
- Source2_select  out  1  1 = immediate is ALU operand B.
- ALU_out_Select  out  1  1 = memory data is write-back source.
- PC_select  out  1  1 = branch/jump target is loaded into PC.
- reg_we  out  1  register-file write strobe.
- mem_we  out  1  data-memory write strobe.
- halted  out  1  core stopped.
- illegal  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Reset (rstn=0 at a clk edge): state=FETCH, PC=0, IR=0, all outputs 0.
  - Reset mid-fetch: imem_req drops the cycle after reset; any imem_valid in flight is discarded.
- FETCH:
  - imem_req=1, imem_addr=PC.
  - On the first edge with imem_valid=1: IR<=imem_rdata, go to DECODE.
  - Otherwise stay in FETCH, unbounded wait.
  - imem_valid in any other state is ignored.
- DECODE:
  - Field outputs reflect IR from this state onward.
  - Source2_select and ALU_out_Select are set from the opcode and held through WB.
- EXEC:
  - BEQ samples alu_zero here; the result is latched as taken.
  - JMP is always taken.
- WB:
  - reg_we=1 for ADD/SUB/AND/OR/XOR/ADDI/LOAD.
  - mem_we=1 for STORE.
  - PC_select=1 when taken.
  - PC update: JMP loads Jump_addr; BEQ taken loads PC+1+sext(Immediate_Addr), truncated to PC_W; otherwise PC+1.
  - PC wraps modulo 2^PC_W.
  - Next state is FETCH.
- reg_we, mem_we and PC_select are single-cycle pulses, asserted only in WB.
- Latency: 4 cycles per instruction with zero-wait memory (FETCH 1 + DECODE + EXEC + WB); each FETCH wait cycle adds 1.
- HALT opcode: at WB, go to HALT and set halted=1. PC is not advanced, and the state holds until reset.
- Undefined opcode: executes as NOP (PC+1, no writes) and pulses illegal in WB.
- Opcodes (OPC_W=4): ADD 0, SUB 1, AND 2, OR 3, XOR 4, ADDI 5, LOAD 6, STORE 7, BEQ 8, JMP 9, NOP F, HALT E; 10-13 undefined.

Optional Feature:
- Macro: CL_PERF_CNT_EN.
- When defined:
  - Adds output instret (32 bits): increments on every WB, saturating at all-ones.
  - Adds output stall_cnt (32 bits): increments on each FETCH cycle with imem_valid=0, saturating.
  - Both counters clear on reset.
- When undefined: neither port nor the counter logic exists; all other behaviour is identical.

Decomposition:
- Package cl_pkg holds:
  - state enum FETCH/DECODE/EXEC/WB/HALT;
  - opcode localparams;
  - default width constants.
- Sub-module cl_decoder: purely combinational, maps opcode to Source2_select, ALU_out_Select, writes_reg, writes_mem, is_branch, is_jump, is_halt, is_illegal.
- The FSM, PC and IR stay in control_logic_fsm.

Test Plan:
- Reset, then imem_valid tied 1 with rdata=0x0A53 (ADD rd=5, rs1=1, rs2=2): imem_addr=0 in cycle 1; Wreg_Sig=5, Rreg_Sig1=1, Rreg_Sig2=2; reg_we pulses exactly in cycle 4; next imem_addr=1.
- ADDI 0x5A47 with 3 wait cycles on imem_valid: Source2_select=1, Immediate_Addr=0x07; reg_we pulses 7 cycles after req rises; stall_cnt=3 (if CL_PERF_CNT_EN).
- BEQ imm=0x3E (-2) at PC=0x10: alu_zero=1 gives PC_select pulse and next PC 0x0F; alu_zero=0 gives next PC 0x11.
- JMP with Jump_addr=0xFF at PC=0x20: next PC 0xFF. A following NOP wraps PC to 0x00.
- Opcode 0xB: illegal pulses 1 cycle, reg_we and mem_we stay 0, PC+1. HALT 0xE000: halted=1, imem_req stays 0 for 20 cycles.
- rstn low for 1 cycle during FETCH wait: all outputs 0 next cycle, PC=0, fetch restarts at address 0.
